writeback_queue: RTL and testbench

WRITEBACK_QUEUE -- requirements
Module: writeback_queue

---
 rtl/writeback_queue.sv | 125 ++++++++++++
 tb/tb_writeback_queue.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_queue.sv
`default_nettype none
// ============================================================================
// writeback_queue : register-file write-back FIFO with hazard lookup.
// Optional youngest-match data forwarding is enabled by the macro WBQ_FWD_EN.
// Revision: 1.0
// ============================================================================
module writeback_queue #(
  parameter int RN    = 5,
  parameter int N     = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [RN-1:0]            in_addr,
  input  logic [N-1:0]             in_data,
  input  logic                     stall,
  output logic                     regWrite,
  output logic [RN-1:0]            A3,
  output logic [N-1:0]             WD,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  input  logic [RN-1:0]            q_addr1,
  input  logic [RN-1:0]            q_addr2,
  output logic                     q_hit1,
  output logic                     q_hit2,
  output logic [N-1:0]             q_data1,
  output logic [N-1:0]             q_data2
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("writeback_queue: DEPTH must be a power of two and at least 2");
  end

  logic [RN-1:0]    addr_mem [DEPTH];
  logic [N-1:0]     data_mem [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic             push;
  logic             pop;
  logic [DEPTH-1:0] occupied;
  logic [DEPTH-1:0] match1;
  logic [DEPTH-1:0] match2;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign in_ready = !full;

  // Address-0 writes are accepted but dropped: x0 is never written back.
  assign push     = in_valid && in_ready && (in_addr != '0);
  assign pop      = !empty && !stall;

  assign regWrite = pop;
  assign A3       = empty ? '0 : addr_mem[head];
  assign WD       = empty ? '0 : data_mem[head];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail] <= in_addr;
      data_mem[tail] <= in_data;
    end
  end

  // A slot is live when its distance from head is below the occupancy.
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic [PW-1:0] offset;
    assign offset      = PW'(i) - head;
    assign occupied[i] = ({1'b0, offset} < count);
    assign match1[i]   = occupied[i] && (addr_mem[i] == q_addr1);
    assign match2[i]   = occupied[i] && (addr_mem[i] == q_addr2);
  end

  assign q_hit1 = (q_addr1 != '0) && (|match1);
  assign q_hit2 = (q_addr2 != '0) && (|match2);

`ifdef WBQ_FWD_EN
  logic [PW-1:0] idx1;
  logic [PW-1:0] idx2;
  logic [N-1:0]  fwd1;
  logic [N-1:0]  fwd2;

  // Walk oldest to youngest so the youngest matching entry wins.
  always_comb begin
    idx1 = '0;
    idx2 = '0;
    fwd1 = '0;
    fwd2 = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx1 = head + PW'(k);
      idx2 = head + PW'(k);
      if (match1[idx1]) fwd1 = data_mem[idx1];
      if (match2[idx2]) fwd2 = data_mem[idx2];
    end
  end

  assign q_data1 = q_hit1 ? fwd1 : '0;
  assign q_data2 = q_hit2 ? fwd2 : '0;
`else
  assign q_data1 = '0;
  assign q_data2 = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_writeback_queue.sv
`default_nettype none
// ============================================================================
// tb_writeback_queue : vector table plus scoreboard bench for writeback_queue.
// Revision: 1.0
// ============================================================================
module tb_writeback_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_addr;
  logic [31:0] in_data;
  logic        stall;
  logic        regWrite;
  logic [4:0]  A3;
  logic [31:0] WD;
  logic [2:0]  count;
  logic        full;
  logic        empty;
  logic [4:0]  q_addr1;
  logic [4:0]  q_addr2;
  logic        q_hit1;
  logic        q_hit2;
  logic [31:0] q_data1;
  logic [31:0] q_data2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  writeback_queue #(.RN(5), .N(32), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
    .stall(stall), .regWrite(regWrite), .A3(A3), .WD(WD),
    .count(count), .full(full), .empty(empty),
    .q_addr1(q_addr1), .q_addr2(q_addr2),
    .q_hit1(q_hit1), .q_hit2(q_hit2), .q_data1(q_data1), .q_data2(q_data2)
  );

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t sb[$];

  typedef struct {
    logic        v;
    logic [4:0]  a;
    logic [31:0] d;
    logic        st;
    logic [4:0]  qa1;
    logic [4:0]  qa2;
    int          ec;
    logic        erw;
    logic        eh1;
    logic [31:0] ed1;
  } vec_t;

  vec_t tbl[22];

  function automatic logic [31:0] fv(input logic [31:0] x);
`ifdef WBQ_FWD_EN
    return x;
`else
    return 32'h0 & x;
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic lookup(input logic [4:0] qa, output logic hit, output logic [31:0] dat);
    hit = 1'b0;
    dat = 32'h0;
    if (qa != 5'd0) begin
      foreach (sb[i]) begin
        if (sb[i].a == qa) begin
          hit = 1'b1;
          dat = sb[i].d;
        end
      end
    end
    dat = fv(dat);
  endtask

  // Checks all outputs against the scoreboard, then applies this edge's push/pop.
  task automatic model_step();
    logic        erw;
    logic        epush;
    logic        h;
    logic [31:0] dd;
    int          sz;
    sz    = sb.size();
    erw   = (sz != 0) && !stall;
    epush = in_valid && (sz < 4) && (in_addr != 5'd0);
    chk("count", 64'(count), 64'(sz));
    chk("full", 64'(full), 64'(sz == 4));
    chk("empty", 64'(empty), 64'(sz == 0));
    chk("in_ready", 64'(in_ready), 64'(sz < 4));
    chk("regWrite", 64'(regWrite), 64'(erw));
    if (sz != 0) begin
      chk("A3", 64'(A3), 64'(sb[0].a));
      chk("WD", 64'(WD), 64'(sb[0].d));
    end else begin
      chk("A3_empty", 64'(A3), 64'h0);
      chk("WD_empty", 64'(WD), 64'h0);
    end
    lookup(q_addr1, h, dd);
    chk("q_hit1", 64'(q_hit1), 64'(h));
    chk("q_data1", 64'(q_data1), 64'(dd));
    lookup(q_addr2, h, dd);
    chk("q_hit2", 64'(q_hit2), 64'(h));
    chk("q_data2", 64'(q_data2), 64'(dd));
    if (erw) void'(sb.pop_front());
    if (epush) sb.push_back('{a: in_addr, d: in_data});
  endtask

  task automatic cycle();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] a, input logic [31:0] d, input logic st);
    in_valid = v;
    in_addr  = a;
    in_data  = d;
    stall    = st;
  endtask

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; in_addr = '0; in_data = '0;
    stall = 1'b0; q_addr1 = '0; q_addr2 = '0;
    //        v  a    d          st qa1  qa2  ec rw h1 d1
    tbl[0]  = '{1, 5'd3, 32'hA,  0, 5'd0, 5'd0, 0, 0, 0, 32'h0};
    tbl[1]  = '{1, 5'd4, 32'hB,  0, 5'd0, 5'd0, 1, 1, 0, 32'h0};
    tbl[2]  = '{0, 5'd0, 32'h0,  0, 5'd0, 5'd0, 1, 1, 0, 32'h0};
    tbl[3]  = '{0, 5'd0, 32'h0,  0, 5'd0, 5'd0, 0, 0, 0, 32'h0};
    tbl[4]  = '{1, 5'd0, 32'hFF, 0, 5'd0, 5'd0, 0, 0, 0, 32'h0};
    tbl[5]  = '{0, 5'd0, 32'h0,  0, 5'd0, 5'd0, 0, 0, 0, 32'h0};
    tbl[6]  = '{1, 5'd1, 32'h11, 1, 5'd0, 5'd0, 0, 0, 0, 32'h0};
    tbl[7]  = '{1, 5'd2, 32'h22, 1, 5'd0, 5'd0, 1, 0, 0, 32'h0};
    tbl[8]  = '{1, 5'd5, 32'h33, 1, 5'd0, 5'd0, 2, 0, 0, 32'h0};
    tbl[9]  = '{1, 5'd6, 32'h44, 1, 5'd0, 5'd5, 3, 0, 0, 32'h0};
    tbl[10] = '{1, 5'd9, 32'h55, 1, 5'd0, 5'd0, 4, 0, 0, 32'h0};
    tbl[11] = '{0, 5'd0, 32'h0,  0, 5'd0, 5'd0, 4, 1, 0, 32'h0};
    tbl[12] = '{0, 5'd0, 32'h0,  0, 5'd0, 5'd0, 3, 1, 0, 32'h0};
    tbl[13] = '{0, 5'd0, 32'h0,  0, 5'd0, 5'd0, 2, 1, 0, 32'h0};
    tbl[14] = '{0, 5'd0, 32'h0,  0, 5'd0, 5'd0, 1, 1, 0, 32'h0};
    tbl[15] = '{0, 5'd0, 32'h0,  0, 5'd0, 5'd0, 0, 0, 0, 32'h0};
    tbl[16] = '{1, 5'd7, 32'h1,  1, 5'd7, 5'd0, 0, 0, 0, 32'h0};
    tbl[17] = '{1, 5'd7, 32'h2,  1, 5'd7, 5'd0, 1, 0, 1, fv(32'h1)};
    tbl[18] = '{0, 5'd0, 32'h0,  1, 5'd7, 5'd0, 2, 0, 1, fv(32'h2)};
    tbl[19] = '{0, 5'd0, 32'h0,  0, 5'd7, 5'd0, 2, 1, 1, fv(32'h2)};
    tbl[20] = '{0, 5'd0, 32'h0,  0, 5'd7, 5'd0, 1, 1, 1, fv(32'h2)};
    tbl[21] = '{0, 5'd0, 32'h0,  0, 5'd0, 5'd0, 0, 0, 0, 32'h0};

    #1 rst_n = 1'b0;
    #1;
    chk("rst_count", 64'(count), 64'h0);
    chk("rst_empty", 64'(empty), 64'h1);
    chk("rst_full", 64'(full), 64'h0);
    chk("rst_in_ready", 64'(in_ready), 64'h1);
    chk("rst_regWrite", 64'(regWrite), 64'h0);
    chk("rst_A3", 64'(A3), 64'h0);
    chk("rst_WD", 64'(WD), 64'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].st);
      q_addr1 = tbl[i].qa1;
      q_addr2 = tbl[i].qa2;
      @(negedge clk);
      chk($sformatf("vec%0d_count", i), 64'(count), 64'(tbl[i].ec));
      chk($sformatf("vec%0d_regWrite", i), 64'(regWrite), 64'(tbl[i].erw));
      chk($sformatf("vec%0d_hit1", i), 64'(q_hit1), 64'(tbl[i].eh1));
      chk($sformatf("vec%0d_data1", i), 64'(q_data1), 64'(tbl[i].ed1));
      model_step();
      @(posedge clk);
      #1;
    end

    // Steady push+pop at occupancy 2 across several pointer wraps.
    drive(1, 5'd20, 32'h100, 1); cycle();
    drive(1, 5'd21, 32'h101, 1); cycle();
    for (int i = 0; i < 10; i++) begin
      drive(1, 5'(10 + i), $urandom, 0);
      @(negedge clk);
      chk($sformatf("wrap%0d_count", i), 64'(count), 64'h2);
      model_step();
      @(posedge clk);
      #1;
    end
    drive(0, 5'd0, 32'h0, 0);
    for (int i = 0; i < 3; i++) cycle();
    chk("wrap_drained", 64'(sb.size()), 64'h0);

    // Reset while draining three pending entries.
    q_addr1 = 5'd25;
    drive(1, 5'd25, 32'hC1, 1); cycle();
    drive(1, 5'd26, 32'hC2, 1); cycle();
    drive(1, 5'd27, 32'hC3, 1); cycle();
    drive(0, 5'd0, 32'h0, 0);
    #1;
    chk("pre_rst_regWrite", 64'(regWrite), 64'h1);
    chk("pre_rst_hit1", 64'(q_hit1), 64'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_regWrite", 64'(regWrite), 64'h0);
    chk("mid_rst_count", 64'(count), 64'h0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'h1);
    chk("mid_rst_hit1", 64'(q_hit1), 64'h0);
    chk("mid_rst_A3", 64'(A3), 64'h0);
    sb.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    drive(1, 5'd8, 32'h77, 0); cycle();
    drive(0, 5'd0, 32'h0, 0);
    for (int i = 0; i < 3; i++) cycle();
    chk("post_rst_drained", 64'(sb.size()), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
